// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - Philips I2S stereo transmitter with one-pair holding register.
// Optional saturating underrun counter is enabled with `define I2S_TX_UNDERRUN_CNT_EN.
module i2s_tx_serializer #(
  parameter int SLOT_BITS = 32,
  parameter int BCLK_DIV  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [2:0]  sample_size,
  input  logic [31:0] s_left,
  input  logic [31:0] s_right,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        bclk,
  output logic        ws,
  output logic        sdata,
`ifdef I2S_TX_UNDERRUN_CNT_EN
  output logic [15:0] underrun_cnt,
`endif
  output logic        underrun
);

  localparam int FRAME = 2 * SLOT_BITS;
  localparam int KW    = $clog2(FRAME);
  localparam int DW    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [5:0]    SLOT_SZ = 6'(SLOT_BITS);
  localparam logic [KW-1:0] K_LAST  = KW'(FRAME - 1);

  logic [DW-1:0] div_cnt;
  logic [KW-1:0] k;
  logic [31:0]   hold_l, hold_r, frm_l, frm_r;
  logic [5:0]    hold_size, frm_size;
  logic          hold_valid;

  logic [5:0]    size_dec;
  logic          tick, fall_tick, frame_start, accept, ws_next;
  logic [KW-1:0] k_next;
  logic [31:0]   cur_l, cur_r;
  logic [5:0]    cur_size;

  // Selects the bit for slot position kk; positions past the sample size are padding zeros.
  function automatic logic data_bit(input logic [31:0] l, input logic [31:0] r,
                                    input logic [5:0] sz, input logic [KW-1:0] kk);
    logic [6:0]  pos;
    logic [6:0]  idx;
    logic [31:0] w;
    if (7'(kk) < 7'(SLOT_BITS)) begin
      pos = 7'(kk);
      w   = l;
    end else begin
      pos = 7'(kk) - 7'(SLOT_BITS);
      w   = r;
    end
    idx = 7'(sz) - 7'd1 - pos;
    return (pos < 7'(sz)) ? w[idx[4:0]] : 1'b0;
  endfunction

  always_comb begin
    case (sample_size)
      3'd0:    size_dec = 6'd8;
      3'd1:    size_dec = 6'd12;
      3'd2:    size_dec = 6'd16;
      3'd3:    size_dec = 6'd24;
      default: size_dec = 6'd32;
    endcase
    if (size_dec > SLOT_SZ) size_dec = SLOT_SZ;
  end

  assign s_ready     = !hold_valid;
  assign accept      = s_valid && !hold_valid;
  assign tick        = enable && (div_cnt == DW'(BCLK_DIV - 1));
  assign fall_tick   = tick && bclk;
  assign k_next      = (k == K_LAST) ? '0 : k + 1'b1;
  assign frame_start = fall_tick && (k == K_LAST);
  assign ws_next     = (k_next >= KW'(SLOT_BITS - 1)) && (k_next <= KW'(FRAME - 2));

  // At frame start the new word is taken straight from the holding register (or muted).
  always_comb begin
    cur_l    = frm_l;
    cur_r    = frm_r;
    cur_size = frm_size;
    if (frame_start) begin
      cur_l    = hold_valid ? hold_l    : 32'd0;
      cur_r    = hold_valid ? hold_r    : 32'd0;
      cur_size = hold_valid ? hold_size : 6'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      k          <= K_LAST;
      bclk       <= 1'b0;
      ws         <= 1'b0;
      sdata      <= 1'b0;
      underrun   <= 1'b0;
      hold_valid <= 1'b0;
      hold_l     <= '0;
      hold_r     <= '0;
      hold_size  <= '0;
      frm_l      <= '0;
      frm_r      <= '0;
      frm_size   <= '0;
    end else begin
      underrun <= frame_start && !hold_valid;
      if (accept) begin
        hold_l     <= s_left;
        hold_r     <= s_right;
        hold_size  <= size_dec;
        hold_valid <= 1'b1;
      end else if (frame_start) begin
        hold_valid <= 1'b0;
      end
      if (!enable) begin
        div_cnt <= '0;
        k       <= K_LAST;
        bclk    <= 1'b0;
        ws      <= 1'b0;
        sdata   <= 1'b0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) bclk <= !bclk;
        if (fall_tick) begin
          k     <= k_next;
          ws    <= ws_next;
          sdata <= data_bit(cur_l, cur_r, cur_size, k_next);
        end
        if (frame_start) begin
          frm_l    <= cur_l;
          frm_r    <= cur_r;
          frm_size <= cur_size;
        end
      end
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      underrun_cnt <= '0;
    else if (frame_start && !hold_valid && underrun_cnt != 16'hFFFF)
      underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif

endmodule
